// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, register-select codes, 8N1 frame shape.
// Used by both the TX peripheral and the future RX peripheral.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam logic [1:0] TX_SEL  = 2'b01;
    localparam logic [1:0] RX_SEL  = 2'b10;
    localparam logic [1:0] CLR_SEL = 2'b11;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..BAUD_DIV-1 while enabled and ticks on the last count.
// Tick is combinational from the registered count; clear and reset force the count to 0.
module uart_baud_gen #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned CW = $clog2(BAUD_DIV);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(BAUD_DIV - 1));
    assign o_tick = i_en && w_last;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter; tx/busy/done are registered, so a frame starts one cycle after the write.
// No queueing: a TX write while a frame is in flight is dropped; done is sticky until cleared or a new frame starts.
module uart_tx_periph #(
    parameter int unsigned BAUD_DIV = 434,
    parameter logic [1:0]  TX_SEL   = uart_pkg::TX_SEL,
    parameter logic [1:0]  CLR_SEL  = uart_pkg::CLR_SEL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_i,
    input  logic [1:0]  reg_sel_i,
    input  logic        wr_i,
    output logic        tx_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] status_o
);
    import uart_pkg::*;

    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    uart_state_t          r_state, w_state_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [IDX_W-1:0]     r_idx, w_idx_nxt;
    logic                 r_tx, r_busy, r_done;
    logic                 w_tx_nxt;
    logic                 w_accept, w_clr, w_tick, w_baud_en, w_frame_end;
    logic                 w_unused_hi;

    assign w_unused_hi = ^data_i[31:DATA_BITS];

    assign w_accept  = wr_i && (reg_sel_i == TX_SEL) && (r_state == ST_IDLE);
    assign w_clr     = wr_i && (reg_sel_i == CLR_SEL);
    assign w_baud_en = (r_state != ST_IDLE);

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_baud_en),
        .i_clr  (w_accept),
        .o_tick (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        w_frame_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_START;
                    w_shift_nxt = data_i[DATA_BITS-1:0];
                    w_idx_nxt   = '0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt = ST_DATA;
                    w_idx_nxt   = '0;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_idx == IDX_W'(DATA_BITS - 1)) begin
                        w_state_nxt = ST_STOP;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            ST_STOP: begin
                // Bit index is reused to count stop bits.
                if (w_tick) begin
                    if (r_idx == IDX_W'(STOP_BITS - 1)) begin
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = '0;
                        w_frame_end = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Line level is derived from the next state so tx_o is registered without an extra cycle of lag.
        case (w_state_nxt)
            ST_START: w_tx_nxt = 1'b0;
            ST_DATA:  w_tx_nxt = w_shift_nxt[0];
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_idx   <= w_idx_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            // Frame completion beats a coincident clear.
            if (w_frame_end) begin
                r_done <= 1'b1;
            end else if (w_clr || w_accept) begin
                r_done <= 1'b0;
            end
        end
    end

    assign tx_o     = r_tx;
    assign busy_o   = r_busy;
    assign done_o   = r_done;
    assign status_o = {30'b0, r_done, r_busy};

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed and randomized checks of uart_tx_periph against a frame-level model.
module tb_uart_tx_periph;

    localparam int BD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_i;
    logic [1:0]  reg_sel_i;
    logic        wr_i;
    logic        tx_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] status_o;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_periph #(
        .BAUD_DIV (BD),
        .TX_SEL   (2'b01),
        .CLR_SEL  (2'b11)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_i    (data_i),
        .reg_sel_i (reg_sel_i),
        .wr_i      (wr_i),
        .tx_o      (tx_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .status_o  (status_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, "_tx"},     {31'b0, tx_o},   32'd1);
        chk({tag, "_busy"},   {31'b0, busy_o}, 32'd0);
        chk({tag, "_done"},   {31'b0, done_o}, {31'b0, exp_done});
        chk({tag, "_status"}, status_o,        {30'b0, exp_done, 1'b0});
    endtask

    // Sends one frame and checks every cycle of it against the expected 8N1 waveform.
    // An optional extra write (inj_sel/inj_dat) is presented during cycle inj_at of the frame.
    task automatic run_frame(input logic [31:0] d, input int inj_at,
                             input logic [1:0] inj_sel, input logic [31:0] inj_dat);
        logic [9:0] bits;
        bits      = {1'b1, d[7:0], 1'b0};
        data_i    = d;
        reg_sel_i = 2'b01;
        wr_i      = 1'b1;
        step();
        for (int c = 0; c < 10*BD; c++) begin
            chk("frame_tx",     {31'b0, tx_o},   {31'b0, bits[c/BD]});
            chk("frame_busy",   {31'b0, busy_o}, 32'd1);
            chk("frame_status", status_o,        32'd1);
            wr_i      = (c == inj_at);
            reg_sel_i = inj_sel;
            data_i    = inj_dat;
            step();
        end
        wr_i = 1'b0;
        chk_idle("frame_end", 1'b1);
    endtask

    initial begin
        logic [31:0] rnd;
        reset     = 1'b1;
        wr_i      = 1'b0;
        data_i    = '0;
        reg_sel_i = '0;
        repeat (3) step();
        chk_idle("reset", 1'b0);
        reset = 1'b0;
        step();
        chk_idle("post_reset", 1'b0);

        run_frame(32'h0000_0055, -1, 2'b00, 32'h0);
        run_frame(32'h0000_01A5, -1, 2'b10, $urandom());

        // Non-TX/non-clear selects must neither start a frame nor clear done.
        wr_i = 1'b1; reg_sel_i = 2'b00; data_i = 32'h12; step();
        reg_sel_i = 2'b10; step();
        wr_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_idle("ignored_sel", 1'b1);
            step();
        end

        wr_i = 1'b1; reg_sel_i = 2'b11; step();
        wr_i = 1'b0;
        chk_idle("clear_done", 1'b0);

        // TX write mid-frame is dropped; no second frame follows.
        run_frame(32'h0000_000F, 10, 2'b01, 32'h0000_00FF);
        for (int i = 0; i < 12; i++) begin
            step();
            chk_idle("no_requeue", 1'b1);
        end

        // Clear on the exact STOP->IDLE edge: set wins.
        run_frame(32'h0000_003C, 10*BD-1, 2'b11, 32'h0);

        // Back-to-back: second write lands in the first IDLE cycle.
        run_frame(32'h0000_0081, -1, 2'b00, 32'h0);
        run_frame(32'h0000_007E, -1, 2'b00, 32'h0);

        // Reset in the middle of a frame.
        data_i = 32'h0000_00A5; reg_sel_i = 2'b01; wr_i = 1'b1; step();
        wr_i = 1'b0;
        repeat (17) step();
        chk("pre_reset_tx",   {31'b0, tx_o},   32'd0);
        chk("pre_reset_busy", {31'b0, busy_o}, 32'd1);
        reset = 1'b1; step();
        chk_idle("mid_reset", 1'b0);
        reset = 1'b0; step(); step();
        chk_idle("after_reset", 1'b0);
        run_frame($urandom(), -1, 2'b00, 32'h0);

        // Randomized frames with idle noise and random in-frame writes.
        for (int k = 0; k < 6; k++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                wr_i      = 1'($urandom_range(0, 1));
                reg_sel_i = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b10;
                data_i    = $urandom();
                step();
                chk_idle("rand_gap", 1'b1);
            end
            wr_i = 1'b0;
            rnd  = $urandom();
            run_frame(rnd, int'($urandom_range(0, 10*BD-1)),
                      2'($urandom_range(0, 3)), $urandom());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
